// File: rtl/fetch_pkg.sv
// Shared widths, state encoding and reset default for the fetch stage.
package fetch_pkg;

    localparam int OPCODE_W = 4;
    localparam int IMM_W    = 12;
    localparam int INSTR_W  = 16;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: holds unless advance is set, then steps by PC_STEP or loads target.
// Single-cycle update; no backpressure of its own, the caller decides when to advance.
module fetch_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        load,
    input  logic [15:0] target,
    output logic [15:0] pc
);

    localparam logic [15:0] STEP = 16'(PC_STEP);

    // Increment wraps modulo 2^16 without any flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (advance) begin
            pc <= load ? target : pc + STEP;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, request/ready instruction read, IR split into opcode/immediate; one instr per 2 cycles.
// Stall holds the VALID instruction; optional REQ timeout to a sticky ERR state under FETCH_TIMEOUT_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          PC_STEP        = 2,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                CLK,
    input  logic                RST_N,
    output logic                MemReq,
    output logic [15:0]         MemAddr,
    input  logic [INSTR_W-1:0]  MemRdata,
    input  logic                MemReady,
    input  logic                Stall,
    input  logic                PCLoad,
    input  logic [15:0]         PCTarget,
    output logic                InstValid,
    output logic [OPCODE_W-1:0] Opcode,
    output logic [IMM_W-1:0]    Imm,
    output logic [15:0]         PC,
    output logic                FetchErr
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [INSTR_W-1:0] ir;
    logic               mem_req;
    logic               accept;
    logic               capture;

`ifdef FETCH_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;
`endif

    assign accept  = (state == VALID) && !Stall;
    assign capture = (state == REQ) && MemReady;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = REQ;
            REQ: begin
                // A completion on the limit cycle still counts as a successful fetch.
                if (MemReady) begin
                    state_nxt = VALID;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    state_nxt = ERR;
                end
`endif
            end
            VALID: if (!Stall) state_nxt = REQ;
`ifdef FETCH_TIMEOUT_EN
            ERR:   state_nxt = ERR;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            mem_req <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_req <= (state_nxt == REQ);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir <= '0;
        end else if (capture) begin
            ir <= MemRdata;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Held at zero outside REQ so every REQ entry starts a fresh count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt <= '0;
        end else if (state != REQ) begin
            to_cnt <= '0;
        end else if (!MemReady) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign FetchErr = (state == ERR);
`else
    assign FetchErr = 1'b0;
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk     (CLK),
        .rst_n   (RST_N),
        .advance (accept),
        .load    (PCLoad),
        .target  (PCTarget),
        .pc      (PC)
    );

    assign MemReq    = mem_req;
    assign MemAddr   = PC;
    assign InstValid = (state == VALID);
    assign Opcode    = ir[INSTR_W-1 -: OPCODE_W];
    assign Imm       = ir[IMM_W-1:0];

endmodule
